// File: rtl/scope_cmd_engine_if.sv
// Command/response and SPI handshake bundle between scope_cmd_engine and its peers.
// master: the command engine; slave: UART receiver/transmitter and SPI master side.
interface scope_cmd_engine_if;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;
  logic [15:0] SPI_data;
  logic        wrt_SPI;
  logic [2:0]  ss;
  logic        SPI_done;
  logic [7:0]  EEP_data;

  modport master (
    input  cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
    output clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
    input  clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
  );
endinterface

// File: rtl/scope_cmd_engine.sv
// Host command decoder for the capture front end: config registers, SPI kicks, responses.
// Define SCOPE_CMD_SPI_TIMEOUT_EN to enable the SPI_WAIT watchdog (limit SPI_TO cycles).
module scope_cmd_engine #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned TRIG_POS_W = 9,
  parameter int unsigned DEC_W      = 4,
  parameter int unsigned SPI_TO     = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  scope_cmd_engine_if.master    bus,
  input  logic                  set_capture_done_i,
  output logic [7:0]            trig_cfg_o,
  output logic [TRIG_POS_W-1:0] trig_pos_o,
  output logic [DEC_W-1:0]      decimator_o,
  output logic [3*NUM_CH-1:0]   gain_o,
  output logic                  dump_o,
  output logic [1:0]            dump_ch_o,
  output logic                  rclk_o,
  output logic                  adc_clk_o
);

  typedef enum logic [1:0] {StIdle, StDecode, StSpiWait, StResp} state_e;

  localparam logic [7:0] OpDump    = 8'h01;
  localparam logic [7:0] OpCfgGain = 8'h02;
  localparam logic [7:0] OpTrigLvl = 8'h03;
  localparam logic [7:0] OpTrigPos = 8'h04;
  localparam logic [7:0] OpSetDec  = 8'h05;
  localparam logic [7:0] OpTrigCfg = 8'h06;
  localparam logic [7:0] OpTrigRd  = 8'h07;
  localparam logic [7:0] OpEepWrt  = 8'h08;
  localparam logic [7:0] OpEepRd   = 8'h09;
  localparam logic [7:0] OpGainRd  = 8'h0A;
  localparam logic [7:0] RespAck   = 8'hA5;
  localparam logic [7:0] RespErr   = 8'hEE;

  state_e                state_q, state_d;
  logic [23:0]           cmd_q, cmd_d;
  logic [7:0]            resp_data_q, resp_data_d;
  logic [15:0]           spi_data_q, spi_data_d;
  logic [2:0]            ss_q, ss_d;
  logic [5:0]            trig_cfg_q, trig_cfg_d;
  logic [TRIG_POS_W-1:0] trig_pos_q, trig_pos_d;
  logic [DEC_W-1:0]      dec_q, dec_d;
  logic [3*NUM_CH-1:0]   gain_q, gain_d;
  logic [1:0]            dump_ch_q, dump_ch_d;
  logic                  rclk_q;

  logic       send_resp, wrt_spi, clr_cmd_rdy, dump;
  logic       respond;
  logic [7:0] resp_val;

  logic [7:0]  opcode, byte2, byte3;
  logic [15:0] arg;
  logic [1:0]  ch;
  logic [2:0]  g;
  logic        ch_ok;
  logic        lvl_ok;
  logic [2:0]  gain_sel;

  assign opcode = cmd_q[23:16];
  assign byte2  = cmd_q[15:8];
  assign byte3  = cmd_q[7:0];
  assign arg    = cmd_q[15:0];
  assign ch     = byte2[1:0];
  assign g      = byte2[4:2];
  assign ch_ok  = 32'(ch) < NUM_CH;
  assign lvl_ok = (byte3 >= 8'd46) && (byte3 <= 8'd201);

  // AFE pot codes for the eight gain steps.
  function automatic logic [7:0] gain_lut(input logic [2:0] sel);
    unique case (sel)
      3'd0: return 8'h02;
      3'd1: return 8'h05;
      3'd2: return 8'h09;
      3'd3: return 8'h14;
      3'd4: return 8'h28;
      3'd5: return 8'h46;
      3'd6: return 8'h6B;
      3'd7: return 8'hDD;
    endcase
  endfunction

  always_comb begin
    gain_sel = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch == 2'(i)) gain_sel = gain_q[3*i +: 3];
    end
  end

`ifdef SCOPE_CMD_SPI_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(SPI_TO + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Counts SPI_WAIT cycles; held at zero elsewhere so it clears on entry.
  assign to_cnt_d = (state_q == StSpiWait) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_spi_to;
  assign unused_spi_to = ^SPI_TO;
`endif

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{arg, byte2[7:5]};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    resp_data_d = resp_data_q;
    spi_data_d  = spi_data_q;
    ss_d        = ss_q;
    trig_cfg_d  = trig_cfg_q;
    trig_pos_d  = trig_pos_q;
    dec_d       = dec_q;
    gain_d      = gain_q;
    dump_ch_d   = dump_ch_q;
    send_resp   = 1'b0;
    wrt_spi     = 1'b0;
    clr_cmd_rdy = 1'b0;
    dump        = 1'b0;
    respond     = 1'b0;
    resp_val    = RespErr;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_rdy) begin
          cmd_d   = bus.cmd;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Default outcome is an error response with no register change.
        respond = 1'b1;
        state_d = StResp;
        case (opcode)
          OpDump: if (ch_ok) begin
            respond     = 1'b0;
            dump        = 1'b1;
            dump_ch_d   = ch;
            clr_cmd_rdy = 1'b1;
            state_d     = StIdle;
          end
          OpCfgGain: if (ch_ok) begin
            respond    = 1'b0;
            wrt_spi    = 1'b1;
            ss_d       = {1'b0, ch};
            spi_data_d = {8'h13, gain_lut(g)};
            state_d    = StSpiWait;
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (ch == 2'(i)) gain_d[3*i +: 3] = g;
            end
          end
          OpTrigLvl: if (lvl_ok) begin
            respond    = 1'b0;
            wrt_spi    = 1'b1;
            ss_d       = 3'b101;
            spi_data_d = {8'h13, byte3};
            state_d    = StSpiWait;
          end
          OpTrigPos: begin
            trig_pos_d = arg[TRIG_POS_W-1:0];
            resp_val   = RespAck;
          end
          OpSetDec: begin
            dec_d    = byte3[DEC_W-1:0];
            resp_val = RespAck;
          end
          OpTrigCfg: begin
            trig_cfg_d = byte2[5:0];
            resp_val   = RespAck;
          end
          OpTrigRd: resp_val = {2'b00, trig_cfg_q};
          OpEepWrt, OpEepRd: begin
            respond    = 1'b0;
            wrt_spi    = 1'b1;
            ss_d       = 3'b100;
            spi_data_d = {1'b0, opcode == OpEepWrt, byte2[5:0], byte3};
            state_d    = StSpiWait;
          end
          OpGainRd: if (ch_ok) resp_val = {5'd0, gain_sel};
          default: ;
        endcase
      end
      StSpiWait: begin
        if (bus.SPI_done) begin
          respond  = 1'b1;
          resp_val = (opcode == OpEepRd) ? bus.EEP_data : RespAck;
          state_d  = StResp;
        end
`ifdef SCOPE_CMD_SPI_TIMEOUT_EN
        else if (to_cnt_q == ToW'(SPI_TO)) begin
          respond  = 1'b1;
          resp_val = RespErr;
          state_d  = StResp;
        end
`endif
      end
      StResp: begin
        if (bus.resp_sent) begin
          clr_cmd_rdy = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (respond) begin
      send_resp   = 1'b1;
      resp_data_d = resp_val;
    end
    // Capture-done wins over a same-cycle TRIG_CFG write.
    if (set_capture_done_i) trig_cfg_d[5] = 1'b1;
    if (rst) begin
      send_resp   = 1'b0;
      wrt_spi     = 1'b0;
      clr_cmd_rdy = 1'b0;
      dump        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      resp_data_q <= '0;
      spi_data_q  <= '0;
      ss_q        <= '0;
      trig_cfg_q  <= '0;
      trig_pos_q  <= '0;
      dec_q       <= '0;
      gain_q      <= '0;
      dump_ch_q   <= '0;
      rclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      resp_data_q <= resp_data_d;
      spi_data_q  <= spi_data_d;
      ss_q        <= ss_d;
      trig_cfg_q  <= trig_cfg_d;
      trig_pos_q  <= trig_pos_d;
      dec_q       <= dec_d;
      gain_q      <= gain_d;
      dump_ch_q   <= dump_ch_d;
      rclk_q      <= ~rclk_q;
    end
  end

  assign bus.clr_cmd_rdy = clr_cmd_rdy;
  assign bus.resp_data   = resp_data_q;
  assign bus.send_resp   = send_resp;
  assign bus.SPI_data    = spi_data_q;
  assign bus.wrt_SPI     = wrt_spi;
  assign bus.ss          = ss_q;
  assign trig_cfg_o      = {2'b00, trig_cfg_q};
  assign trig_pos_o      = trig_pos_q;
  assign decimator_o     = dec_q;
  assign gain_o          = gain_q;
  assign dump_o          = dump;
  assign dump_ch_o       = dump_ch_q;
  assign rclk_o          = rclk_q;
  assign adc_clk_o       = ~rclk_q;

endmodule
